spi_serf: RTL and testbench

- SPI responder (serf) for the team's 16-bit SPI monarch.
- Receives a 16-bit command on MOSI while returning a pre-loaded 16-bit word on MISO in the same transaction.
- SPI mode matches the monarch: SCLK idles high, data is sampled on SCLK rise and changed on SCLK fall, MSB first.
- Oversamples SS_n/SCLK/MOSI in the clk domain; sits behind pads or a bus bridge and presents received commands with a ready flag.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_serf.sv | 143 ++++++++++++++
 tb/tb_spi_serf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: packet width and responder FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous pin with one-clk rise/fall pulses.
// Pulses appear while the second flop holds the new level and the third the old.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain plus edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c_o = ~s3_q & s2_q;
    assign fall_c_o = s3_q & ~s2_q;

endmodule

// File: rtl/spi_serf.sv
// SPI responder: SCLK idles high, sample on rise, shift on fall, MSB first.
// Receives a command on MOSI while returning the pre-loaded word on MISO.
module spi_serf
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             wrt,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shft_reg_q, shft_reg_d;
    logic [WIDTH-1:0]   cmd_q, cmd_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               smpl_q, smpl_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               mosi_s1_q, mosi_s2_q;

    logic               ss_rise, ss_fall;
    logic               sclk_rise, sclk_fall;
    logic               last_c;
    logic               rdy_set_c;
    logic [WIDTH-1:0]   shifted_c;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (SS_n),
        .rise_c_o (ss_rise),
        .fall_c_o (ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (SCLK),
        .rise_c_o (sclk_rise),
        .fall_c_o (sclk_fall)
    );

    // MOSI only needs a level, so a plain two-flop synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shft_reg_q <= '0;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            smpl_q     <= 1'b0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shft_reg_q <= shft_reg_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            smpl_q     <= smpl_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    assign last_c    = (bit_cnt_q == LAST_BIT);
    assign shifted_c = {shft_reg_q[WIDTH-2:0], smpl_q};

    // Next-state: select starts a transfer, first SCLK rise enters SHIFT, deselect ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ARMED;
            ARMED: begin
                if (ss_rise)        state_d = IDLE;
                else if (sclk_rise) state_d = SHIFT;
            end
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates; the front-porch fall in ARMED is ignored and a fall
    // at the last bit is held so the final shift happens on deselect.
    always_comb begin
        shft_reg_d = shft_reg_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        smpl_d     = smpl_q;
        rdy_set_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wrt)     shft_reg_d = tx_data;
                if (ss_fall) bit_cnt_d  = '0;
            end
            ARMED: begin
                if (sclk_rise) smpl_d = mosi_s2_q;
            end
            SHIFT: begin
                if (sclk_rise) smpl_d = mosi_s2_q;
                if (ss_rise) begin
                    if (last_c) begin
                        shft_reg_d = shifted_c;
                        cmd_d      = shifted_c;
                        rdy_set_c  = 1'b1;
                    end
                end else if (sclk_fall && !last_c) begin
                    shft_reg_d = shifted_c;
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Completion takes priority over a same-cycle clear.
        if (rdy_set_c)                     cmd_rdy_d = 1'b1;
        else if (clr_cmd_rdy || ss_fall)   cmd_rdy_d = 1'b0;
        else                               cmd_rdy_d = cmd_rdy_q;
    end

    assign MISO    = shft_reg_q[WIDTH-1];
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a behavioural SPI monarch drives transactions and a
// word-level model predicts cmd, cmd_rdy and the data returned on MISO.
module tb_spi_serf;
    import spi_pkg::*;

    localparam int unsigned W = 16;
    localparam int HALF = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         SS_n = 1'b1;
    logic         SCLK = 1'b1;
    logic         MOSI = 1'b0;
    logic         wrt = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         clr_cmd_rdy = 1'b0;
    logic         MISO;
    logic [W-1:0] cmd;
    logic         cmd_rdy;

    int checks = 0;
    int failures = 0;

    // Model: word the responder will return, last command, ready flag.
    logic [W-1:0] m_shft = '0;
    logic [W-1:0] m_cmd = '0;
    logic         m_rdy = 1'b0;

    spi_serf #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n        (SS_n),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .wrt         (wrt),
        .tx_data     (tx_data),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] d);
        tx_data = d;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        m_shft = d;
        check("miso_after_load", W'(MISO), W'(d[W-1]));
    endtask

    // One monarch transaction with n SCLK rises. tail adds a trailing fall
    // before deselect, keep_ss leaves SS_n low, clr_end holds clr_cmd_rdy
    // across completion, wrt_mid pulses wrt with 16'hDEAD during shifting.
    task automatic xfer(input logic [W-1:0] c, input int n, input bit tail,
                        input bit keep_ss, input bit clr_end, input bit wrt_mid);
        logic [W-1:0] rd;
        logic [W-1:0] exp_rd;
        logic [31:0]  tmp;
        int           s;
        rd = '0;
        tmp = 32'(m_shft) >> (W - n);
        exp_rd = W'(tmp);
        SS_n = 1'b0;
        tick(HALF);
        m_rdy = 1'b0;
        check("rdy_clr_on_ss_fall", W'(cmd_rdy), W'(m_rdy));
        SCLK = 1'b0;
        MOSI = c[W-1];
        tick(HALF);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b1;
            rd = {rd[W-2:0], MISO};
            if (wrt_mid && i == 4) begin
                tx_data = 16'hDEAD;
                wrt = 1'b1;
                tick(1);
                wrt = 1'b0;
                tick(HALF - 1);
            end else begin
                tick(HALF);
            end
            if (i < n - 1) begin
                SCLK = 1'b0;
                MOSI = c[W-2-i];
                tick(HALF);
            end
        end
        check("rd_data", rd, exp_rd);
        if (keep_ss) return;
        if (tail) begin
            SCLK = 1'b0;
            tick(HALF);
        end
        if (clr_end) clr_cmd_rdy = 1'b1;
        SS_n = 1'b1;
        if (n == W) begin
            m_shft = c;
            m_cmd = c;
            m_rdy = 1'b1;
        end else begin
            s = n - 1;
            if (s > 0) begin
                tmp = (32'(m_shft) << s) | (32'(c) >> (W - s));
                m_shft = W'(tmp);
            end
        end
        if (clr_end) begin
            tick(3);
            check("set_beats_clr", W'(cmd_rdy), W'(m_rdy));
            clr_cmd_rdy = 1'b0;
            tick(2);
        end else begin
            tick(5);
        end
        check("cmd", cmd, m_cmd);
        check("cmd_rdy", W'(cmd_rdy), W'(m_rdy));
        check("state_idle", W'(dut.state_q), W'(IDLE));
        if (tail) SCLK = 1'b1;
        tick(HALF);
    endtask

    initial begin
        logic [W-1:0] r;
        int           n;
        bit           tl;

        // Reset state
        tick(3);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_rdy", W'(cmd_rdy), 16'h0000);
        check("rst_miso", W'(MISO), 16'h0000);
        rst_n = 1'b1;
        tick(4);

        // Basic exchange
        load(16'hA5C3);
        xfer(16'h1234, W, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back with reload; ready drops at the second select
        load(16'h0000);
        xfer(16'hFFFF, W, 1'b0, 1'b0, 1'b0, 1'b0);

        // Consumer acknowledge
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check("clr_cmd_rdy", W'(cmd_rdy), W'(m_rdy));

        // No reload: second transaction echoes the first command
        xfer(16'h8001, W, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(16'h7FFE, W, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort after 7 rises, then a full transaction
        xfer(16'h3C3C, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(16'hBEEF, W, 1'b0, 1'b0, 1'b0, 1'b0);

        // wrt during shifting is ignored
        load(16'h1111);
        xfer(16'h2468, W, 1'b0, 1'b0, 1'b0, 1'b1);
        xfer(16'h0F0F, W, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset at bit 9 of a transfer
        load(16'h9876);
        xfer(16'h4321, 9, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_shft = '0;
        m_cmd = '0;
        m_rdy = 1'b0;
        check("midrst_miso", W'(MISO), 16'h0000);
        check("midrst_cmd", cmd, m_cmd);
        check("midrst_rdy", W'(cmd_rdy), W'(m_rdy));
        SS_n = 1'b1;
        SCLK = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        load(16'h5A5A);
        xfer(16'hC0DE, W, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized transactions
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1, 0) == 1) load(W'($urandom));
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 1)) : int'(W);
            tl = (n == int'(W)) && ($urandom_range(1, 0) == 1);
            r = W'($urandom);
            xfer(r, n, tl, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
